// File: rtl/md5_msg_sched.sv
// MD5 message scheduler: packs an ASCII byte stream into padded 512-bit blocks,
// drives the compression core, chains A/B/C/D and streams the digest as ASCII hex.
`timescale 1ns/1ps
module md5_msg_sched #(
    parameter int HEX_LOWER = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    input  logic         byte_last,
    output logic         byte_ready,
    output logic         blk_start,
    output logic [511:0] blk_data,
    output logic [31:0]  iv_a,
    output logic [31:0]  iv_b,
    output logic [31:0]  iv_c,
    output logic [31:0]  iv_d,
    input  logic         core_done,
    input  logic [31:0]  core_a,
    input  logic [31:0]  core_b,
    input  logic [31:0]  core_c,
    input  logic [31:0]  core_d,
    output logic [127:0] digest,
    output logic         digest_valid,
    output logic         hex_valid,
    output logic [7:0]   hex_data,
    input  logic         hex_ready
);

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hEFCDAB89;
    localparam logic [31:0] IV_C = 32'h98BADCFE;
    localparam logic [31:0] IV_D = 32'h10325476;

    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_HEX} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [511:0]   r_blk;
    logic [6:0]     r_cnt;
    logic [63:0]    r_len;
    logic           r_tail_pend;
    logic           r_final;
    logic           r_tail80;
    logic [5:0]     r_nib;
    logic [31:0]    r_a, r_b, r_c, r_d;
    logic [127:0]   r_digest;
    logic           r_dvld;
    logic           r_armed;

    logic           w_accept;
    logic [6:0]     w_n;
    logic [63:0]    w_len_inc;
    logic [511:0]   w_fill_blk;
    logic [511:0]   w_tail_blk;
    logic [31:0]    w_sum_a, w_sum_b, w_sum_c, w_sum_d;
    logic [7:0]     w_dig_byte;
    logic [3:0]     w_nibble;
    logic [7:0]     w_hex_char;

    assign w_accept  = (r_state == S_FILL) && r_armed && byte_valid;
    assign w_n       = r_cnt + 7'd1;
    assign w_len_inc = r_len + 64'd8;
    assign w_sum_a   = r_a + core_a;
    assign w_sum_b   = r_b + core_b;
    assign w_sum_c   = r_c + core_c;
    assign w_sum_d   = r_d + core_d;

    // Block image after writing the offered byte, with padding when it is the last one
    always_comb begin
        w_fill_blk = r_blk;
        for (int i = 0; i < 64; i++) begin
            if (7'(i) == r_cnt) begin
                w_fill_blk[8*i +: 8] = byte_data;
            end else if (byte_last && (7'(i) == w_n)) begin
                w_fill_blk[8*i +: 8] = 8'h80;
            end
        end
        if (byte_last && (w_n <= 7'd55)) begin
            w_fill_blk[511:448] = w_len_inc;
        end
    end

    always_comb begin
        w_tail_blk          = '0;
        w_tail_blk[7:0]     = r_tail80 ? 8'h80 : 8'h00;
        w_tail_blk[511:448] = r_len;
    end

    always_comb begin
        w_dig_byte = r_digest[{r_nib[4:1], 3'b000} +: 8];
        w_nibble   = r_nib[0] ? w_dig_byte[3:0] : w_dig_byte[7:4];
        if (w_nibble < 4'd10) begin
            w_hex_char = 8'h30 + {4'h0, w_nibble};
        end else begin
            w_hex_char = ((HEX_LOWER != 0) ? 8'h57 : 8'h37) + {4'h0, w_nibble};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        byte_ready  = 1'b0;
        blk_start   = 1'b0;
        hex_valid   = 1'b0;
        hex_data    = 8'h00;
        case (r_state)
            S_FILL: begin
                byte_ready = r_armed;
                if (w_accept && (byte_last || (r_cnt == 7'd63))) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                blk_start   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    if (r_tail_pend) begin
                        w_state_nxt = S_ISSUE;
                    end else if (r_final) begin
                        w_state_nxt = S_HEX;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_HEX: begin
                hex_valid = 1'b1;
                hex_data  = w_hex_char;
                if (hex_ready && (r_nib == 6'd31)) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_tail_pend <= 1'b0;
            r_final     <= 1'b0;
            r_tail80    <= 1'b0;
            r_nib       <= '0;
            r_a         <= IV_A;
            r_b         <= IV_B;
            r_c         <= IV_C;
            r_d         <= IV_D;
            r_digest    <= '0;
            r_dvld      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_dvld  <= (r_state == S_WAIT) && core_done && !r_tail_pend && r_final;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_blk <= w_fill_blk;
                        r_cnt <= w_n;
                        r_len <= w_len_inc;
                        if (byte_last) begin
                            r_final     <= (w_n <= 7'd55);
                            r_tail_pend <= (w_n > 7'd55);
                            r_tail80    <= (w_n == 7'd64);
                        end else if (r_cnt == 7'd63) begin
                            r_final     <= 1'b0;
                            r_tail_pend <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_a <= w_sum_a;
                        r_b <= w_sum_b;
                        r_c <= w_sum_c;
                        r_d <= w_sum_d;
                        if (r_tail_pend) begin
                            r_blk       <= w_tail_blk;
                            r_tail_pend <= 1'b0;
                            r_tail80    <= 1'b0;
                            r_final     <= 1'b1;
                        end else if (r_final) begin
                            r_digest <= {w_sum_d, w_sum_c, w_sum_b, w_sum_a};
                            r_nib    <= '0;
                        end else begin
                            r_blk <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                S_HEX: begin
                    if (hex_ready) begin
                        if (r_nib == 6'd31) begin
                            r_a     <= IV_A;
                            r_b     <= IV_B;
                            r_c     <= IV_C;
                            r_d     <= IV_D;
                            r_cnt   <= '0;
                            r_len   <= '0;
                            r_blk   <= '0;
                            r_final <= 1'b0;
                        end else begin
                            r_nib <= r_nib + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign blk_data     = r_blk;
    assign iv_a         = r_a;
    assign iv_b         = r_b;
    assign iv_c         = r_c;
    assign iv_d         = r_d;
    assign digest       = r_digest;
    assign digest_valid = r_dvld;

endmodule

// File: tb/tb_md5_msg_sched.sv
// Bench for md5_msg_sched: behavioural MD5 core, reference padding/digest model,
// randomized messages and hand-off timing.
`timescale 1ns/1ps
module tb_md5_msg_sched;

    localparam logic [127:0] IV = {32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};

    logic         clk, reset;
    logic         byte_valid, byte_last, byte_ready;
    logic [7:0]   byte_data;
    logic         blk_start, core_done, digest_valid, hex_valid, hex_ready;
    logic [511:0] blk_data;
    logic [31:0]  iv_a, iv_b, iv_c, iv_d, core_a, core_b, core_c, core_d;
    logic [127:0] digest;
    logic [7:0]   hex_data;

    int checks = 0, errors = 0;

    md5_msg_sched #(.HEX_LOWER(1)) dut (
        .clk(clk), .reset(reset),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
        .blk_start(blk_start), .blk_data(blk_data),
        .iv_a(iv_a), .iv_b(iv_b), .iv_c(iv_c), .iv_d(iv_d),
        .core_done(core_done), .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .digest(digest), .digest_valid(digest_valid),
        .hex_valid(hex_valid), .hex_data(hex_data), .hex_ready(hex_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] K [64];
    int          S [64];

    task automatic init_tables();
        int sh [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
        real r;
        for (int i = 0; i < 64; i++) begin
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            K[i] = 32'(longint'($floor(r * 4294967296.0)));
            S[i] = sh[i / 16][i % 4];
        end
    endtask

    // MD5 64-step transform; chain layout {D,C,B,A}, returns the round outputs (no feed-forward)
    function automatic logic [127:0] md5_rounds(input logic [511:0] blk, input logic [127:0] ch);
        logic [31:0] a, b, c, d, f, tmp;
        int g;
        a = ch[31:0]; b = ch[63:32]; c = ch[95:64]; d = ch[127:96];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            f = f + a + K[i] + blk[32*g +: 32];
            tmp = d; d = c; c = b;
            b = b + ((f << S[i]) | (f >> (32 - S[i])));
            a = tmp;
        end
        return {d, c, b, a};
    endfunction

    // Behavioural compression core
    logic [511:0] cap_blk [$];
    logic [127:0] cap_iv  [$];
    int           done_cnt = 0, lat_ovr = -1, stale_req_cnt = 0, stale_done = 0;
    logic [511:0] c_blk;
    logic [127:0] c_iv, c_res;
    bit           c_busy = 0;
    int           c_lat;

    initial begin
        core_done = 1'b0;
        {core_d, core_c, core_b, core_a} = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (reset) begin
                c_busy = 0;
            end else if (stale_req_cnt != stale_done) begin
                stale_done = stale_req_cnt;
                core_a = $urandom; core_b = $urandom; core_c = $urandom; core_d = $urandom;
                core_done = 1'b1;
            end else if (c_busy) begin
                if (c_lat <= 0) begin
                    c_res = md5_rounds(c_blk, c_iv);
                    {core_d, core_c, core_b, core_a} = c_res;
                    core_done = 1'b1;
                    c_busy = 0;
                    done_cnt++;
                end else begin
                    c_lat--;
                end
            end else if (blk_start) begin
                c_blk = blk_data;
                c_iv  = {iv_d, iv_c, iv_b, iv_a};
                cap_blk.push_back(blk_data);
                cap_iv.push_back(c_iv);
                c_busy = 1;
                c_lat  = (lat_ovr >= 0) ? lat_ovr : int'($urandom_range(0, 4));
            end
        end
    end

    // Activity monitor: blk_start cycles, digest_valid pulses, byte_ready while a block is in flight
    int bs_cycles = 0, dv_cnt = 0, rdy_viol = 0, done_seen = 0;
    bit inflight = 0;

    always @(negedge clk) begin
        if (done_cnt != done_seen) begin
            done_seen = done_cnt;
            inflight  = 0;
        end
        if (reset) begin
            inflight = 0;
        end else begin
            if (blk_start) begin
                inflight = 1;
                bs_cycles++;
            end
            if (digest_valid) dv_cnt++;
            if (inflight && byte_ready) rdy_viol++;
        end
    end

    // Reference model state
    logic [7:0]   msg_q [$];
    logic [511:0] exp_blk [$];
    logic [127:0] exp_iv  [$];
    logic [127:0] exp_dig;
    string        exp_hex, got_hex;
    int           run_base;

    task automatic build_ref();
        logic [7:0]   p [$];
        logic [63:0]  bl;
        logic [127:0] ch, r;
        logic [511:0] blk;
        exp_blk.delete();
        exp_iv.delete();
        p = msg_q;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int j = 0; j < 8; j++) p.push_back(bl[8*j +: 8]);
        ch = IV;
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int i = 0; i < 64; i++) blk[8*i +: 8] = p[64*b + i];
            exp_blk.push_back(blk);
            exp_iv.push_back(ch);
            r = md5_rounds(blk, ch);
            for (int w = 0; w < 4; w++) ch[32*w +: 32] = ch[32*w +: 32] + r[32*w +: 32];
        end
        exp_dig = ch;
        exp_hex = "";
        for (int k = 0; k < 16; k++) exp_hex = {exp_hex, $sformatf("%02x", ch[8*k +: 8])};
    endtask

    function automatic logic [511:0] cap_at(input int idx);
        if (idx < cap_blk.size()) return cap_blk[idx];
        return '0;
    endfunction

    task automatic send_msg();
        int t;
        for (int i = 0; i < msg_q.size(); i++) begin
            t = 0;
            while (byte_ready !== 1'b1 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) begin
                checks++; errors++;
                $display("FAIL send_timeout: byte %0d byte_ready=%b, required 1", i, byte_ready);
                return;
            end
            byte_valid = 1'b1;
            byte_data  = msg_q[i];
            byte_last  = (i == msg_q.size() - 1);
            @(negedge clk);
            byte_valid = 1'b0;
            byte_last  = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    task automatic recv_hex(input int stall0, output string s);
        int t, bad;
        s = "";
        t = 0;
        while (hex_valid !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL hex_start: hex_valid=%b after %0d cycles, required 1", hex_valid, t);
            return;
        end
        checks++;
        if (digest_valid !== 1'b1) begin
            errors++;
            $display("FAIL digest_valid_first_hex: got %b required 1", digest_valid);
        end
        checks++;
        if (digest !== exp_dig) begin
            errors++;
            $display("FAIL digest_value: got %h required %h", digest, exp_dig);
        end
        if (stall0 > 0) begin
            bad = 0;
            hex_ready = 1'b0;
            for (int k = 0; k < stall0; k++) begin
                if (hex_valid !== 1'b1 || hex_data !== exp_hex[0]) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL hex_hold: %0d unstable cycles, last char %h required %h", bad, hex_data, exp_hex[0]);
            end
        end
        for (int k = 0; k < 32; k++) begin
            t = 0;
            while (1) begin
                if (hex_valid === 1'b1 && $urandom_range(0, 3) != 0) break;
                hex_ready = 1'b0;
                @(negedge clk);
                t++;
                if (t > 2000) break;
            end
            if (t > 2000) begin
                checks++; errors++;
                $display("FAIL hex_char_timeout: char %0d hex_valid=%b, required 1", k, hex_valid);
                return;
            end
            hex_ready = 1'b1;
            s = {s, $sformatf("%c", hex_data)};
            @(negedge clk);
            hex_ready = 1'b0;
        end
        checks++;
        if (hex_valid !== 1'b0) begin
            errors++;
            $display("FAIL hex_count: hex_valid=%b after 32 chars, required 0", hex_valid);
        end
    endtask

    task automatic run_msg(input int stall0);
        int bs0, dv0, rv0, nb;
        build_ref();
        run_base = cap_blk.size();
        bs0 = bs_cycles; dv0 = dv_cnt; rv0 = rdy_viol;
        send_msg();
        recv_hex(stall0, got_hex);
        nb = cap_blk.size() - run_base;
        checks++;
        if (nb != exp_blk.size()) begin
            errors++;
            $display("FAIL block_count: got %0d required %0d (msg len %0d)", nb, exp_blk.size(), msg_q.size());
        end
        for (int b = 0; b < exp_blk.size(); b++) begin
            checks++;
            if (cap_at(run_base + b) !== exp_blk[b]) begin
                errors++;
                $display("FAIL block_data[%0d]: got %h required %h", b, cap_at(run_base + b), exp_blk[b]);
            end
            if (run_base + b < cap_iv.size()) begin
                checks++;
                if (cap_iv[run_base + b] !== exp_iv[b]) begin
                    errors++;
                    $display("FAIL block_iv[%0d]: got %h required %h", b, cap_iv[run_base + b], exp_iv[b]);
                end
            end
        end
        checks++;
        if (bs_cycles - bs0 != exp_blk.size()) begin
            errors++;
            $display("FAIL blk_start_cycles: got %0d required %0d", bs_cycles - bs0, exp_blk.size());
        end
        checks++;
        if (dv_cnt - dv0 != 1) begin
            errors++;
            $display("FAIL digest_valid_pulses: got %0d required 1", dv_cnt - dv0);
        end
        checks++;
        if (rdy_viol != rv0) begin
            errors++;
            $display("FAIL byte_ready_busy: got %0d cycles ready while block in flight, required 0", rdy_viol - rv0);
        end
        checks++;
        if (got_hex != exp_hex) begin
            errors++;
            $display("FAIL hex_stream: got %s required %s", got_hex, exp_hex);
        end
        checks++;
        if (digest !== exp_dig) begin
            errors++;
            $display("FAIL digest_hold: got %h required %h", digest, exp_dig);
        end
        checks++;
        if (byte_ready !== 1'b1 || {iv_d, iv_c, iv_b, iv_a} !== IV) begin
            errors++;
            $display("FAIL back_to_fill: byte_ready=%b iv=%h required 1 and %h", byte_ready, {iv_d, iv_c, iv_b, iv_a}, IV);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, blk_start, digest_valid, hex_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/start/dvalid/hvalid=%b required 0000",
                     {byte_ready, blk_start, digest_valid, hex_valid});
        end
        checks++;
        if (blk_data !== '0 || digest !== '0 || hex_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: blk=%h digest=%h hex=%h required zeros", blk_data, digest, hex_data);
        end
        checks++;
        if ({iv_d, iv_c, iv_b, iv_a} !== IV) begin
            errors++;
            $display("FAIL reset_iv: got %h required %h", {iv_d, iv_c, iv_b, iv_a}, IV);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", byte_ready);
        end
    endtask

    task automatic test_abc();
        logic [511:0] b0;
        msg_q = {8'h61, 8'h62, 8'h63};
        run_msg(0);
        b0 = cap_at(run_base);
        checks++;
        if (b0[31:0] !== 32'h80636261 || b0[511:448] !== 64'd24) begin
            errors++;
            $display("FAIL abc_block: word0=%h len=%0d required 80636261 and 24", b0[31:0], b0[511:448]);
        end
        checks++;
        if (digest[31:0] !== 32'h98500190) begin
            errors++;
            $display("FAIL abc_digest: got %h required 98500190", digest[31:0]);
        end
        checks++;
        if (got_hex != "900150983cd24fb0d6963f7d28e17f72") begin
            errors++;
            $display("FAIL abc_hex: got %s required 900150983cd24fb0d6963f7d28e17f72", got_hex);
        end
    endtask

    task automatic fill_a(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'h61);
    endtask

    task automatic test_len55();
        logic [511:0] b0;
        fill_a(55);
        run_msg(0);
        b0 = cap_at(run_base);
        checks++;
        if (cap_blk.size() - run_base != 1 || b0[8*55 +: 8] !== 8'h80 || b0[511:448] !== 64'd440) begin
            errors++;
            $display("FAIL len55: blocks=%0d byte55=%h len=%0d required 1, 80, 440",
                     cap_blk.size() - run_base, b0[8*55 +: 8], b0[511:448]);
        end
    endtask

    task automatic test_len56();
        logic [511:0] b0, b1;
        fill_a(56);
        run_msg(0);
        b0 = cap_at(run_base);
        b1 = cap_at(run_base + 1);
        checks++;
        if (b0[8*56 +: 8] !== 8'h80 || b0[511:456] !== '0) begin
            errors++;
            $display("FAIL len56_first: byte56=%h tail=%h required 80 and 0", b0[8*56 +: 8], b0[511:456]);
        end
        checks++;
        if (b1[447:0] !== '0 || b1[511:448] !== 64'd448) begin
            errors++;
            $display("FAIL len56_tail: body=%h len=%0d required 0 and 448", b1[447:0], b1[511:448]);
        end
    endtask

    task automatic test_len64();
        logic [511:0] b0, b1;
        fill_a(64);
        run_msg(0);
        b0 = cap_at(run_base);
        b1 = cap_at(run_base + 1);
        checks++;
        if (b0 !== {64{8'h61}}) begin
            errors++;
            $display("FAIL len64_first: got %h required all 61", b0);
        end
        checks++;
        if (b1[7:0] !== 8'h80 || b1[447:8] !== '0 || b1[511:448] !== 64'd512) begin
            errors++;
            $display("FAIL len64_tail: byte0=%h body=%h len=%0d required 80, 0, 512", b1[7:0], b1[447:8], b1[511:448]);
        end
    endtask

    task automatic test_hex_stall();
        msg_q = {8'h61, 8'h62, 8'h63};
        run_msg(5);
    endtask

    task automatic test_reset_in_wait();
        lat_ovr = 40;
        msg_q = {8'h61, 8'h62, 8'h63};
        send_msg();
        repeat (5) @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0 || blk_data[31:0] !== 32'h80636261) begin
            errors++;
            $display("FAIL wait_before_reset: byte_ready=%b word0=%h required 0 and 80636261", byte_ready, blk_data[31:0]);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0 || blk_start !== 1'b0 || blk_data !== '0 || digest !== '0 ||
            {iv_d, iv_c, iv_b, iv_a} !== IV) begin
            errors++;
            $display("FAIL reset_in_wait: ready=%b start=%b blk0=%h digest=%h iv=%h required reset values",
                     byte_ready, blk_start, blk_data[31:0], digest, {iv_d, iv_c, iv_b, iv_a});
        end
        @(negedge clk);
        reset = 1'b0;
        lat_ovr = -1;
        repeat (3) @(negedge clk);
        stale_req_cnt++;
        repeat (3) @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1 || {iv_d, iv_c, iv_b, iv_a} !== IV || blk_start !== 1'b0) begin
            errors++;
            $display("FAIL stale_done: ready=%b iv=%h start=%b required 1, %h, 0",
                     byte_ready, {iv_d, iv_c, iv_b, iv_a}, IV, blk_start);
        end
        run_msg(0);
        checks++;
        if (digest[31:0] !== 32'h98500190) begin
            errors++;
            $display("FAIL abc_after_reset: got %h required 98500190", digest[31:0]);
        end
    endtask

    task automatic test_random();
        int lens [8] = '{1, 54, 57, 63, 65, 119, 120, 0};
        lens[7] = $urandom_range(2, 190);
        for (int m = 0; m < 8; m++) begin
            msg_q.delete();
            for (int i = 0; i < lens[m]; i++) msg_q.push_back(8'($urandom_range(32, 126)));
            run_msg($urandom_range(0, 2));
        end
    endtask

    initial begin
        init_tables();
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        hex_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_abc();
        test_len55();
        test_len56();
        test_len64();
        test_hex_stall();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
